// File: rtl/sr_bank_arb.sv
// Round-robin arbiter that lets N_REQ requesters issue set/reset commands to a shared bank of SR cells.
// IDLE picks a winner and latches its command; APPLY writes the cell and pulses ack (with err for a rejected command).
module sr_bank_arb #(
  parameter int N_REQ  = 4,
  parameter int N_BITS = 8,
  parameter int AW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [2*N_REQ-1:0]  cmd,
  input  logic [AW*N_REQ-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic                err,
  output logic                busy,
  output logic [N_BITS-1:0]   q,
  output logic [N_BITS-1:0]   qbar
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [N_REQ-1:0]  ack_reg, ack_next;
  logic              err_reg, err_next;
  logic [N_BITS-1:0] q_reg, q_next, q_apply;
  logic [1:0]        cap_cmd_reg, cap_cmd_next;
  logic [AW-1:0]     cap_addr_reg, cap_addr_next;
  logic [PW-1:0]     win_reg, win_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [PW-1:0]     win_sel;
  logic              found;
  logic [N_REQ-1:0]  eligible;
  logic              addr_ok;
  logic              cmd_bad;
  logic [1:0]        cmd_arr  [N_REQ];
  logic [AW-1:0]     addr_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign cmd_arr[gi]  = cmd[2*gi +: 2];
      assign addr_arr[gi] = addr[AW*gi +: AW];
    end
  endgenerate

  // A requester whose ack is still showing has just been served; masking it stops a lingering req from re-winning.
  assign eligible = req & ~ack_reg;

  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_sel = PW'(idx);
      end
    end
  end

  assign addr_ok = (int'(cap_addr_reg) < N_BITS);
  assign cmd_bad = (cap_cmd_reg == 2'b11);

  generate
    for (gi = 0; gi < N_BITS; gi++) begin : g_cell
      logic hit;
      assign hit = addr_ok && (int'(cap_addr_reg) == gi);
      assign q_apply[gi] = !hit                  ? q_reg[gi] :
                           (cap_cmd_reg == 2'b10) ? 1'b1      :
                           (cap_cmd_reg == 2'b01) ? 1'b0      : q_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next      = '0;
    ack_next      = '0;
    err_next      = 1'b0;
    q_next        = q_reg;
    cap_cmd_next  = cap_cmd_reg;
    cap_addr_next = cap_addr_reg;
    win_next      = win_reg;
    ptr_next      = ptr_reg;
    if (state_reg == IDLE) begin
      if (found) begin
        gnt_next      = N_REQ'(1) << win_sel;
        cap_cmd_next  = cmd_arr[win_sel];
        cap_addr_next = addr_arr[win_sel];
        win_next      = win_sel;
        ptr_next      = (int'(win_sel) == N_REQ - 1) ? '0 : win_sel + 1'b1;
      end
    end else begin
      ack_next = N_REQ'(1) << win_reg;
      err_next = cmd_bad | ~addr_ok;
      q_next   = q_apply;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg      <= '0;
      ack_reg      <= '0;
      err_reg      <= 1'b0;
      q_reg        <= '0;
      cap_cmd_reg  <= '0;
      cap_addr_reg <= '0;
      win_reg      <= '0;
      ptr_reg      <= '0;
    end else begin
      gnt_reg      <= gnt_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      q_reg        <= q_next;
      cap_cmd_reg  <= cap_cmd_next;
      cap_addr_reg <= cap_addr_next;
      win_reg      <= win_next;
      ptr_reg      <= ptr_next;
    end
  end

  assign gnt  = gnt_reg;
  assign ack  = ack_reg;
  assign err  = err_reg;
  assign busy = (state_reg == APPLY);
  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: tb/tb_sr_bank_arb.sv
// Bench for sr_bank_arb: table of single-requester commands plus fairness, masking, reset and out-of-range sequences.
// Expected acks are queued at stimulus time and matched whenever an ack appears.
module tb_sr_bank_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [11:0] addr;
  logic [3:0]  gnt, ack;
  logic        err, busy;
  logic [7:0]  q, qbar;
  logic [3:0]  gnt6, ack6;
  logic        err6, busy6;
  logic [5:0]  q6, qbar6;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    logic [7:0] q;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         rq;
    logic [1:0] c;
    logic [2:0] a;
    logic [7:0] eq;
    logic       ee;
  } vec_t;
  vec_t vt[12];

  sr_bank_arb #(.N_REQ(4), .N_BITS(8), .AW(3)) u_dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy), .q(q), .qbar(qbar)
  );

  // Narrower bank so that an in-range address field can still point past the last cell.
  sr_bank_arb #(.N_REQ(4), .N_BITS(6), .AW(3)) u_dut6 (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr),
    .gnt(gnt6), .ack(ack6), .err(err6), .busy(busy6), .q(q6), .qbar(qbar6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then check invariants and any ack against the scoreboard.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    chk("gnt_onehot0", {31'b0, $onehot0(gnt)}, 32'd1);
    chk("qbar_inv", {24'b0, qbar}, {24'b0, ~q});
    chk("err_without_ack", {31'b0, (err && (ack == 4'b0))}, 32'd0);
    chk("no_x", {31'b0, $isunknown({gnt, ack, err, busy, q, qbar})}, 32'd0);
    chk("busy_vs_gnt", {31'b0, busy}, {31'b0, |gnt});
    if (ack !== 4'b0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", {28'b0, ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack", {28'b0, ack}, {28'b0, e.ack});
        chk("sb_err", {31'b0, err}, {31'b0, e.err});
        chk("sb_q", {24'b0, q}, {24'b0, e.q});
      end
    end
  endtask

  task automatic set_req(input int rq, input logic [1:0] c, input logic [2:0] a);
    cmd = 8'($urandom);
    addr = 12'($urandom);
    cmd[2*rq +: 2] = c;
    addr[3*rq +: 3] = a;
    req = 4'b0001 << rq;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Idle edge, grant edge, apply edge; cmd/addr are scrambled after the grant.
  task automatic txn(input int rq, input logic [1:0] c, input logic [2:0] a,
                     input logic [7:0] eq, input logic ee);
    logic [3:0] oh;
    oh = 4'b0001 << rq;
    req = 4'b0;
    cyc();
    set_req(rq, c, a);
    sb.push_back('{oh, ee, eq});
    cyc();
    chk("txn_gnt", {28'b0, gnt}, {28'b0, oh});
    chk("txn_busy", {31'b0, busy}, 32'd1);
    cmd = 8'($urandom);
    addr = 12'($urandom);
    cyc();
    chk("txn_gnt_clear", {28'b0, gnt}, 32'd0);
    chk("txn_sb_drained", sb.size(), 32'd0);
    req = 4'b0;
  endtask

  initial begin
    logic [3:0] order[5];

    vt[0]  = '{0, 2'b10, 3'd4, 8'h1F, 1'b0};
    vt[1]  = '{1, 2'b10, 3'd5, 8'h3F, 1'b0};
    vt[2]  = '{3, 2'b10, 3'd6, 8'h7F, 1'b0};
    vt[3]  = '{2, 2'b10, 3'd7, 8'hFF, 1'b0};
    vt[4]  = '{2, 2'b11, 3'd3, 8'hFF, 1'b1};
    vt[5]  = '{2, 2'b01, 3'd3, 8'hF7, 1'b0};
    vt[6]  = '{3, 2'b00, 3'd0, 8'hF7, 1'b0};
    vt[7]  = '{1, 2'b01, 3'd0, 8'hF6, 1'b0};
    vt[8]  = '{0, 2'b11, 3'd1, 8'hF6, 1'b1};
    vt[9]  = '{0, 2'b01, 3'd7, 8'h76, 1'b0};
    vt[10] = '{3, 2'b10, 3'd3, 8'h7E, 1'b0};
    vt[11] = '{1, 2'b01, 3'd6, 8'h3E, 1'b0};

    rst = 1'b1;
    req = 4'b0;
    cmd = 8'b0;
    addr = 12'b0;

    // Reset state
    do_reset();
    chk("rst_gnt", {28'b0, gnt}, 32'd0);
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_q", {24'b0, q}, 32'd0);
    chk("rst_qbar", {24'b0, qbar}, 32'h0000_00FF);

    // Single command from reset, and an address past the end of the narrow bank
    txn(0, 2'b10, 3'd5, 8'h20, 1'b0);
    chk("single_qbar", {24'b0, qbar}, 32'h0000_00DF);
    chk("n6_ack", {28'b0, ack6}, 32'd1);
    chk("n6_err", {31'b0, err6}, 32'd0);
    chk("n6_q", {26'b0, q6}, 32'h20);
    txn(0, 2'b10, 3'd6, 8'h60, 1'b0);
    chk("n6_oob_ack", {28'b0, ack6}, 32'd1);
    chk("n6_oob_err", {31'b0, err6}, 32'd1);
    chk("n6_oob_q", {26'b0, q6}, 32'h20);

    // Fairness with all four requesting continuously
    do_reset();
    req = 4'b1111;
    cmd = 8'b1010_1010;
    addr = {3'd3, 3'd2, 3'd1, 3'd0};
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    sb.push_back('{4'b0001, 1'b0, 8'h01});
    sb.push_back('{4'b0010, 1'b0, 8'h03});
    sb.push_back('{4'b0100, 1'b0, 8'h07});
    sb.push_back('{4'b1000, 1'b0, 8'h0F});
    sb.push_back('{4'b0001, 1'b0, 8'h0F});
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k % 2 == 1) chk("fair_gnt", {28'b0, gnt}, {28'b0, order[(k-1)/2]});
      else            chk("fair_gap", {28'b0, gnt}, 32'd0);
      if (k == 9) req = 4'b0;
    end
    chk("fair_sb_drained", sb.size(), 32'd0);
    chk("fair_q", {24'b0, q}, 32'h0F);

    // Table-driven single-requester commands starting from q=0x0F
    foreach (vt[i]) txn(vt[i].rq, vt[i].c, vt[i].a, vt[i].eq, vt[i].ee);

    // req0 held past its ack while req1 waits: req1 wins the ack cycle
    req = 4'b0;
    cyc();
    req = 4'b0011;
    cmd = 8'b0000_0110;
    addr = {3'd0, 3'd0, 3'd1, 3'd0};
    sb.push_back('{4'b0001, 1'b0, 8'h3F});
    sb.push_back('{4'b0010, 1'b0, 8'h3D});
    cyc();
    chk("mask_gnt0", {28'b0, gnt}, 32'd1);
    cyc();
    chk("mask_ack0", {28'b0, ack}, 32'd1);
    cyc();
    chk("mask_gnt1", {28'b0, gnt}, 32'd2);
    req = 4'b0;
    cyc();
    chk("mask_sb_drained", sb.size(), 32'd0);

    // Lone requester held past ack is not re-granted in the ack cycle
    cyc();
    set_req(0, 2'b00, 3'd0);
    sb.push_back('{4'b0001, 1'b0, 8'h3D});
    cyc();
    chk("hold_gnt", {28'b0, gnt}, 32'd1);
    cyc();
    chk("hold_ack", {28'b0, ack}, 32'd1);
    cyc();
    chk("hold_no_regrant", {28'b0, gnt}, 32'd0);
    req = 4'b0;
    cyc();

    // Reset during APPLY discards the command and restarts the pointer at 0
    set_req(1, 2'b10, 3'd7);
    cyc();
    chk("rmid_gnt", {28'b0, gnt}, 32'd2);
    rst = 1'b1;
    cyc();
    chk("rmid_ack", {28'b0, ack}, 32'd0);
    chk("rmid_gnt_clear", {28'b0, gnt}, 32'd0);
    chk("rmid_q", {24'b0, q}, 32'd0);
    chk("rmid_qbar", {24'b0, qbar}, 32'hFF);
    req = 4'b0101;
    cmd = 8'b0000_0001;
    addr = 12'b0;
    rst = 1'b0;
    sb.push_back('{4'b0001, 1'b0, 8'h00});
    cyc();
    chk("rmid_ptr0", {28'b0, gnt}, 32'd1);
    req = 4'b0;
    cyc();
    chk("rmid_sb_drained", sb.size(), 32'd0);
    cyc();
    chk("final_idle", {28'b0, gnt}, 32'd0);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_bank_arb.md
SR_BANK_ARB -- requirements
Module: sr_bank_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the SR bank.
REQ-002 Parameter N_BITS, default 8, number of SR storage cells in the bank.
REQ-003 Parameter AW, default 3, cell address width; SHALL satisfy 2**AW >= N_BITS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  N_REQ  per-requester command request; held high until that requester's ack.
REQ-007 cmd  input  2*N_REQ  packed {s,r} per requester; requester i at bits [2i+1:2i], s is the upper bit.
REQ-008 addr  input  AW*N_REQ  packed cell address per requester; requester i at bits [AW*i+AW-1:AW*i].
REQ-009 gnt  output  N_REQ  registered one-hot grant; at most one bit high.
REQ-010 ack  output  N_REQ  registered one-cycle completion pulse per requester.
REQ-011 err  output  1  one-cycle pulse, coincident with ack, for a rejected command.
REQ-012 busy  output  1  high while FSM is in APPLY.
REQ-013 q  output  N_BITS  SR cell states.
REQ-014 qbar  output  N_BITS  always bitwise ~q, including during and after reset.

Function
REQ-015 FSM states: IDLE, APPLY; there SHALL be no other states.
REQ-016 IDLE: eligible = req & ~ack; if eligible nonzero at edge, go to APPLY, set gnt to winner one-hot, capture winner cmd and addr into internal registers.
REQ-017 IDLE with eligible zero: remain IDLE; gnt, ack, err stay 0.
REQ-018 Arbitration: round-robin; search starts at pointer ptr and ascends with wrap from N_REQ-1 to 0; first eligible index wins.
REQ-019 ptr SHALL update to (winner+1) mod N_REQ on every grant; ptr unchanged otherwise.
REQ-020 APPLY: at next edge, update q[captured addr] per captured cmd, pulse ack[winner]=1, clear gnt, return to IDLE.
REQ-021 cmd 00: q unchanged; ack issued, err=0.
REQ-022 cmd 01: q[addr] <= 0; cmd 10: q[addr] <= 1; ack issued, err=0.
REQ-023 cmd 11 is illegal: q unchanged (never X), ack issued with err=1.
REQ-024 Captured addr >= N_BITS: q unchanged, ack issued with err=1.
REQ-025 Only the addressed cell may change; all other q bits hold.
REQ-026 Latency: request sampled at edge t gives gnt visible after t, q update and ack visible after t+1; max throughput one command per 2 cycles.
REQ-027 cmd/addr changes after the grant edge SHALL NOT affect the command in flight.
REQ-028 Requester whose ack is high in IDLE is masked, so a req held one cycle past ack is not re-granted.
REQ-029 Deasserting req while granted SHALL NOT abort the command; it completes and is acked.
REQ-030 busy SHALL equal (state==APPLY).

Reset
REQ-031 rst high at an edge: state=IDLE, ptr=0, gnt=0, ack=0, err=0, busy=0, q=all 0, qbar=all 1, captured cmd/addr=0.
REQ-032 rst dominates every other input, including mid-APPLY: the pending command is discarded, q not updated, no ack issued.
REQ-033 First edge after rst deasserts SHALL be a normal IDLE evaluation.

Verification
REQ-034 Single: req=0001, cmd0=10, addr0=5 -> gnt=0001 next cycle; following cycle q=0x20, qbar=0xDF, ack=0001, err=0.
REQ-035 Fairness: req=1111 held, all cmd 10, addr i -> grant order 0,1,2,3,0 repeating; after 4 commands q=0x0F, one command per 2 cycles.
REQ-036 Illegal: q=0xFF, requester 2 cmd=11 addr=3 -> ack=0100, err=1, q stays 0xFF; then cmd=01 addr=3 -> q=0xF7, err=0.
REQ-037 Reset mid-op: requester 1 granted with cmd=10 addr=7, rst high during APPLY -> no ack, q=0x00, qbar=0xFF, gnt=0, next grant search starts at requester 0.
REQ-038 Hold/mask: req0 held one cycle past ack -> not re-granted that cycle; req1 high simultaneously -> granted in the IDLE cycle carrying ack0.
REQ-039 Bench SHALL check every cycle: gnt one-hot or zero, qbar==~q, err only with an ack, no X on any output after reset.
